multdiv_wb: RTL and testbench

- Iterative signed 32-bit multiply/divide unit for the processor pipeline.
- Feeds the register file's normal write port for rd, or its dedicated $rstatus (r31) write port on exception.
- Runs independently of the main pipeline once started.
- Requests a writeback slot when done and drives the regfile write controls for exactly one cycle when the slot is granted.

---
 rtl/multdiv_wb.sv | 128 ++++++++++++
 tb/tb_multdiv_wb.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/multdiv_wb.sv
// multdiv_wb: iterative signed 32-bit multiply/divide unit with regfile writeback handshake
module multdiv_wb #(
  parameter int WIDTH = 32,
  parameter int ITER = 32,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE = 5
) (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic ctrl_MULT,
  input  logic ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0] ctrl_rd,
  input  logic wb_ack,
  output logic busy,
  output logic wb_req,
  output logic ctrl_writeEnable,
  output logic [4:0] ctrl_writeReg,
  output logic [WIDTH-1:0] data_writeReg,
  output logic rs_write,
  output logic [WIDTH-1:0] rs_writeData,
  output logic data_resultRDY
);
  localparam int CW = $clog2(ITER);
  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;
  state_t state_q, state_d;
  logic op_q, op_d, neg_q, neg_d, dz_q, dz_d, fin_q, fin_d, exc_q, exc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] rd_q, rd_d;
  logic [2*WIDTH-1:0] a_q, a_d, p_q, p_d, prod;
  logic [WIDTH-1:0] b_q, b_d, res_q, res_d, mag_a, mag_b, quo;
  logic [WIDTH:0] rem_t, rem_s;
  logic start, fits, commit;
  // magnitudes, one restoring-divide trial step and sign-corrected results
  always_comb begin
    start = ctrl_MULT ^ ctrl_DIV;
    mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    rem_t = p_q[2*WIDTH-1:WIDTH-1];
    rem_s = rem_t - {1'b0, a_q[WIDTH-1:0]};
    fits = rem_t >= {1'b0, a_q[WIDTH-1:0]};
    prod = neg_q ? -p_q : p_q;
    quo = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  end
  // next-state: latch at start, iterate in RUN, one finishing cycle, hold in WB until granted
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    neg_d = neg_q;
    dz_d = dz_q;
    fin_d = fin_q;
    exc_d = exc_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
    res_d = res_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      op_d = ctrl_DIV;
      neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz_d = (data_operandB == '0) || (data_operandA == {1'b1, {(WIDTH-1){1'b0}}} && &data_operandB);
      fin_d = 1'b0;
      cnt_d = CW'(ITER - 1);
      rd_d = ctrl_rd;
      a_d = {{WIDTH{1'b0}}, ctrl_DIV ? mag_b : mag_a};
      b_d = mag_b;
      p_d = ctrl_DIV ? {{WIDTH{1'b0}}, mag_a} : '0;
    end else if (state_q == RUN && fin_q) begin
      state_d = WB;
      exc_d = op_q ? dz_q : !(&prod[2*WIDTH-1:WIDTH-1] || ~|prod[2*WIDTH-1:WIDTH-1]);
      res_d = op_q ? (dz_q ? '0 : quo) : prod[WIDTH-1:0];
    end else if (state_q == RUN) begin
      fin_d = cnt_q == '0;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      p_d = op_q ? (fits ? {rem_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1} : {rem_t[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0})
                 : (b_q[0] ? p_q + a_q : p_q);
      a_d = op_q ? a_q : a_q << 1;
      b_d = op_q ? b_q : b_q >> 1;
    end else if (state_q == WB && wb_ack) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers, cleared by reset
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_q <= IDLE;
      op_q <= 1'b0;
      neg_q <= 1'b0;
      dz_q <= 1'b0;
      fin_q <= 1'b0;
      exc_q <= 1'b0;
      cnt_q <= '0;
      rd_q <= '0;
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      neg_q <= neg_d;
      dz_q <= dz_d;
      fin_q <= fin_d;
      exc_q <= exc_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
      res_q <= res_d;
    end
  end
  // writeback outputs: fields shown throughout WB, strobes only in the granted cycle
  always_comb begin
    busy = state_q != IDLE;
    wb_req = state_q == WB;
    commit = wb_req && wb_ack;
    data_resultRDY = commit;
    ctrl_writeEnable = commit && !exc_q && rd_q != '0;
    rs_write = commit && exc_q;
    ctrl_writeReg = wb_req ? rd_q : '0;
    data_writeReg = wb_req ? res_q : '0;
    rs_writeData = (wb_req && exc_q) ? WIDTH'(op_q ? DIV_EXC_CODE : MULT_EXC_CODE) : '0;
  end
endmodule

// File: tb/tb_multdiv_wb.sv
// tb_multdiv_wb: directed and randomized checks of multdiv_wb against an arithmetic reference model
module tb_multdiv_wb;
  logic clock = 0, ctrl_reset = 1, ctrl_MULT = 0, ctrl_DIV = 0, wb_ack = 0;
  logic [31:0] data_operandA = 0, data_operandB = 0;
  logic [4:0] ctrl_rd = 0;
  logic busy, wb_req, ctrl_writeEnable, rs_write, data_resultRDY;
  logic [4:0] ctrl_writeReg;
  logic [31:0] data_writeReg, rs_writeData;
  int n_cmp = 0, n_err = 0;

  multdiv_wb dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB), .ctrl_rd(ctrl_rd),
    .wb_ack(wb_ack), .busy(busy), .wb_req(wb_req), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .rs_write(rs_write),
    .rs_writeData(rs_writeData), .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_wbreq"}, 32'(wb_req), 0);
    chk({tag, "_we"}, 32'(ctrl_writeEnable), 0);
    chk({tag, "_wreg"}, 32'(ctrl_writeReg), 0);
    chk({tag, "_wdata"}, data_writeReg, 0);
    chk({tag, "_rsw"}, 32'(rs_write), 0);
    chk({tag, "_rsdata"}, rs_writeData, 0);
    chk({tag, "_rdy"}, 32'(data_resultRDY), 0);
  endtask

  function automatic void model(input bit div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit e);
    longint p;
    if (!div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      e = (p > longint'(32'sh7fffffff)) || (p < longint'(32'sh80000000));
      r = p[31:0];
    end else begin
      e = (b == 0) || (a == 32'h80000000 && b == 32'hffffffff);
      r = e ? 32'h0 : 32'($signed(a) / $signed(b));
    end
  endfunction

  task automatic run_op(input bit div, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input int hold, input bit tied, input bit poke);
    logic [31:0] er;
    bit ee;
    int k;
    model(div, a, b, er, ee);
    @(negedge clock);
    ctrl_MULT = !div; ctrl_DIV = div; data_operandA = a; data_operandB = b; ctrl_rd = rd; wb_ack = tied;
    @(posedge clock); #1;
    ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = $urandom; data_operandB = $urandom; ctrl_rd = 5'($urandom);
    chk("busy_run", 32'(busy), 1);
    k = 0;
    while (!wb_req && k < 40) begin
      @(posedge clock); #1;
      k++;
    end
    chk("latency", 32'(k), 33);
    chk("wb_req", 32'(wb_req), 1);
    chk("wreg", 32'(ctrl_writeReg), 32'(rd));
    chk("wdata", data_writeReg, er);
    if (!tied) begin
      for (int i = 0; i < hold; i++) begin
        chk("hold_rdy", 32'(data_resultRDY), 0);
        chk("hold_we", 32'(ctrl_writeEnable | rs_write), 0);
        ctrl_MULT = poke && i == 3;
        @(posedge clock); #1;
      end
      ctrl_MULT = 0;
      chk("hold_busy", 32'(busy), 1);
      chk("hold_wbreq", 32'(wb_req), 1);
      chk("hold_wdata", data_writeReg, er);
      chk("hold_wreg", 32'(ctrl_writeReg), 32'(rd));
      wb_ack = 1; #1;
    end
    chk("commit_rdy", 32'(data_resultRDY), 1);
    chk("commit_we", 32'(ctrl_writeEnable), 32'(!ee && rd != 0));
    chk("commit_rsw", 32'(rs_write), 32'(ee));
    if (ee) chk("commit_rsdata", rs_writeData, div ? 32'd5 : 32'd4);
    @(posedge clock); #1;
    wb_ack = 0;
    chk("after_busy", 32'(busy), 0);
    chk("after_rdy", 32'(data_resultRDY), 0);
    chk("after_wbreq", 32'(wb_req), 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit seen;
    repeat (2) @(posedge clock);
    #1;
    chk_idle("reset");
    ctrl_reset = 0;
    run_op(0, 32'd7, -32'sd6, 5'd5, 0, 1, 0);
    run_op(0, 32'h00010000, 32'h00010000, 5'd3, 0, 0, 0);
    run_op(1, -32'sd7, 32'd2, 5'd4, 0, 0, 0);
    run_op(1, 32'd5, 32'd0, 5'd6, 2, 0, 0);
    run_op(1, 32'h80000000, 32'hffffffff, 5'd7, 0, 1, 0);
    run_op(1, 32'd100, 32'd7, 5'd9, 10, 0, 1);
    run_op(0, 32'd3, 32'd3, 5'd0, 0, 0, 0);
    run_op(0, 32'd9, -32'sd9, 5'd31, 1, 0, 0);
    run_op(0, 32'h80000000, 32'hffffffff, 5'd8, 0, 1, 0);
    run_op(0, 32'h80000000, 32'd1, 5'd10, 0, 1, 0);
    @(negedge clock);
    ctrl_MULT = 1; ctrl_DIV = 1;
    @(posedge clock); #1;
    ctrl_MULT = 0; ctrl_DIV = 0;
    chk_idle("both_strobes");
    @(negedge clock);
    ctrl_MULT = 1; data_operandA = 32'd11; data_operandB = 32'd13; ctrl_rd = 5'd12; wb_ack = 1;
    @(posedge clock); #1;
    ctrl_MULT = 0;
    repeat (10) @(posedge clock);
    #1;
    chk("mid_busy", 32'(busy), 1);
    ctrl_reset = 1;
    @(posedge clock); #1;
    chk_idle("mid_reset");
    ctrl_reset = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      seen |= wb_req | data_resultRDY | ctrl_writeEnable;
    end
    chk("no_wb_after_reset", 32'(seen), 0);
    wb_ack = 0;
    run_op(0, 32'd2, 32'd3, 5'd2, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($signed(32'($urandom_range(0, 2000))) - 1000);
        2: rb = 0;
        default: begin rb = 32'($urandom_range(0, 65535)); ra = 32'($signed(32'($urandom_range(0, 65535))) - 32768); end
      endcase
      run_op(1'($urandom), ra, rb, 5'($urandom), $urandom_range(0, 4), 1'($urandom), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
